// File: rtl/pll_reset_ceg_pkg.sv
// Shared types and default rates for the PLL-lock reset sequencer and its
// fractional clock-enable generators.
package pll_reset_ceg_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_ACC_WIDTH = 24;

  // Phase increments for a ~42 MHz system clock with a 24-bit accumulator.
  localparam int unsigned NTSC_CPU_INC = 2144802;
  localparam int unsigned NTSC_VDC_INC = 2859736;
  localparam int unsigned PAL_CPU_INC  = 2125683;
  localparam int unsigned PAL_VDC_INC  = 2834244;

  // The enable accumulators only advance while the core is held or running.
  function automatic logic ce_active(input state_e s);
    return (s == HOLD) || (s == RUN);
  endfunction

endpackage

// File: rtl/pll_reset_ceg_clk_en_accum.sv
// Fractional clock-enable: a phase accumulator whose registered carry-out
// gives INC/2^ACC_WIDTH pulses per clk, held at zero while run is low.
module clk_en_accum
  import pll_reset_ceg_pkg::*;
#(
  parameter int          ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int unsigned INC       = NTSC_CPU_INC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic ce
);

  localparam logic [ACC_WIDTH:0] INC_EXT = (ACC_WIDTH + 1)'(INC);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 ce_q;
  logic                 ce_d;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + INC_EXT;
    acc_d = '0;
    ce_d  = 1'b0;
    if (run) begin
      acc_d = sum[ACC_WIDTH-1:0];
      ce_d  = sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/pll_reset_ceg.sv
// Qualifies PLL lock, holds the core in reset for a fixed time with enables
// running, then releases it; any lock loss restarts the whole sequence.
module pll_reset_ceg
  import pll_reset_ceg_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES        = 16,
  parameter int          ACC_WIDTH          = DEFAULT_ACC_WIDTH,
  parameter int unsigned CPU_INC            = NTSC_CPU_INC,
  parameter int unsigned VDC_INC            = NTSC_VDC_INC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic sys_rst_n,
  output logic cpu_ce,
  output logic vdc_ce,
  output logic ready
);

  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       sync_d;
  logic             locked_s;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             run_en;

  // pll_locked is asynchronous; only sync_q[1] is trusted downstream.
  assign sync_d   = {sync_q[0], pll_locked};
  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!locked_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
        STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the registered state only, so they cannot glitch on lock.
  assign run_en    = ce_active(state_q);
  assign sys_rst_n = (state_q == RUN);
  assign ready     = (state_q == RUN);

  clk_en_accum #(
    .ACC_WIDTH (ACC_WIDTH),
    .INC       (CPU_INC)
  ) u_cpu_ce (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_en),
    .ce    (cpu_ce)
  );

  clk_en_accum #(
    .ACC_WIDTH (ACC_WIDTH),
    .INC       (VDC_INC)
  ) u_vdc_ce (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_en),
    .ce    (vdc_ce)
  );

endmodule
